spi_xfer_ctrl: RTL and testbench

Burst sequencer that sits directly upstream of the SPI byte engine (`veryl_Spi`). It buffers CPU-written transmit bytes in a TX FIFO and feeds them one at a time into the engine's `din` handshake. It drains each received byte from the engine's `dout` handshake into an RX FIFO for the CPU. It also owns the active-low chip select, including lead time and inter-burst gap.

---
 rtl/spi_xfer_ctrl.sv | 176 +++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// Burst sequencer between a CPU and the SPI byte engine: TX/RX FIFOs plus chip-select lead/gap timing.
// Optional feature macro SPI_XFER_CTRL_LOOPBACK_EN adds i_loopback, which routes TX bytes straight into RX.
module spi_xfer_ctrl #(
  parameter int unsigned FifoDepth    = 16,
  parameter int unsigned CsLeadCycles = 2,
  parameter int unsigned CsGapCycles  = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       if_tx_valid,
  output logic                       if_tx_ready,
  input  logic [7:0]                 if_tx_bits,
  output logic                       if_rx_valid,
  input  logic                       if_rx_ready,
  output logic [7:0]                 if_rx_bits,
  output logic                       if_spi_din_valid,
  input  logic                       if_spi_din_ready,
  output logic [7:0]                 if_spi_din_bits,
  input  logic                       if_spi_dout_valid,
  output logic                       if_spi_dout_ready,
  input  logic [7:0]                 if_spi_dout_bits,
`ifdef SPI_XFER_CTRL_LOOPBACK_EN
  input  logic                       i_loopback,
`endif
  input  logic                       i_cs_hold,
  input  logic                       i_clr_ovf,
  output logic                       o_cs_n,
  output logic                       o_busy,
  output logic [$clog2(FifoDepth):0] o_tx_count,
  output logic [$clog2(FifoDepth):0] o_rx_count,
  output logic                       o_rx_overflow
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TmrW = 8;
  localparam logic [TmrW-1:0] LeadLoad = TmrW'(CsLeadCycles - 1);
  localparam logic [TmrW-1:0] GapLoad  = TmrW'(CsGapCycles - 1);
  localparam logic [CntW-1:0] Full     = CntW'(FifoDepth);

  typedef enum logic [2:0] {IDLE, LEAD, SEND, WAIT_RX, HOLD, GAP} state_t;

  state_t          state, state_next, after_state;
  logic [TmrW-1:0] tmr, tmr_next;
  logic            lb;

`ifdef SPI_XFER_CTRL_LOOPBACK_EN
  assign lb = i_loopback;
`else
  assign lb = 1'b0;
`endif

  // TX FIFO
  logic [7:0]      tx_mem [FifoDepth];
  logic [PtrW-1:0] tx_wr, tx_rd;
  logic            tx_push, tx_pop, tx_nonempty;
  logic [7:0]      tx_head;

  assign if_tx_ready = o_tx_count != Full;
  assign tx_push     = if_tx_valid && if_tx_ready;
  assign tx_nonempty = o_tx_count != '0;
  assign tx_head     = tx_mem[tx_rd];

  always_ff @(posedge i_clk) begin
    if (tx_push) tx_mem[tx_wr] <= if_tx_bits;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tx_wr      <= '0;
      tx_rd      <= '0;
      o_tx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + PtrW'(1);
      if (tx_pop)  tx_rd <= tx_rd + PtrW'(1);
      case ({tx_push, tx_pop})
        2'b10:   o_tx_count <= o_tx_count + CntW'(1);
        2'b01:   o_tx_count <= o_tx_count - CntW'(1);
        default: ;
      endcase
    end
  end

  // RX FIFO; a pop in the capture cycle frees the slot the incoming byte needs
  logic [7:0]      rx_mem [FifoDepth];
  logic [PtrW-1:0] rx_wr, rx_rd;
  logic            rx_req, rx_push, rx_pop, rx_drop, lb_move;
  logic [7:0]      rx_data;

  assign if_rx_valid = o_rx_count != '0;
  assign if_rx_bits  = rx_mem[rx_rd];
  assign rx_pop      = if_rx_valid && if_rx_ready;
  assign lb_move     = (state == SEND) && lb;
  assign rx_req      = lb_move || (if_spi_dout_ready && if_spi_dout_valid);
  assign rx_push     = rx_req && ((o_rx_count != Full) || rx_pop);
  assign rx_drop     = rx_req && !rx_push;
  assign rx_data     = lb_move ? tx_head : if_spi_dout_bits;

  always_ff @(posedge i_clk) begin
    if (rx_push) rx_mem[rx_wr] <= rx_data;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_wr      <= '0;
      rx_rd      <= '0;
      o_rx_count <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + PtrW'(1);
      if (rx_pop)  rx_rd <= rx_rd + PtrW'(1);
      case ({rx_push, rx_pop})
        2'b10:   o_rx_count <= o_rx_count + CntW'(1);
        2'b01:   o_rx_count <= o_rx_count - CntW'(1);
        default: ;
      endcase
    end
  end

  assign tx_pop = lb_move || ((state == SEND) && if_spi_din_valid && if_spi_din_ready);

  // Where to go once a byte has been returned; loopback pops the head in the same cycle
  always_comb begin
    after_state = lb ? IDLE : GAP;
    if (lb_move ? (o_tx_count > CntW'(1)) : tx_nonempty) after_state = SEND;
    else if (i_cs_hold)                                  after_state = HOLD;
  end

  always_comb begin
    state_next = state;
    tmr_next   = tmr;
    case (state)
      IDLE:    if (tx_nonempty) state_next = lb ? SEND : LEAD;
      LEAD:    if (tmr == '0) state_next = SEND;
               else           tmr_next   = tmr - TmrW'(1);
      SEND:    if (lb_move)                                    state_next = after_state;
               else if (if_spi_din_valid && if_spi_din_ready) state_next = WAIT_RX;
      WAIT_RX: if (if_spi_dout_valid) state_next = after_state;
      HOLD:    if (tx_nonempty)    state_next = SEND;
               else if (!i_cs_hold) state_next = lb ? IDLE : GAP;
      GAP:     if (tmr == '0) state_next = IDLE;
               else           tmr_next   = tmr - TmrW'(1);
      default: state_next = IDLE;
    endcase
    if (state_next == LEAD && state != LEAD) tmr_next = LeadLoad;
    if (state_next == GAP  && state != GAP)  tmr_next = GapLoad;
  end

  // Outputs are registered from the next state so they line up with the state register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state             <= IDLE;
      tmr               <= '0;
      o_cs_n            <= 1'b1;
      o_busy            <= 1'b0;
      if_spi_din_valid  <= 1'b0;
      if_spi_din_bits   <= '0;
      if_spi_dout_ready <= 1'b0;
    end else begin
      state             <= state_next;
      tmr               <= tmr_next;
      o_cs_n            <= (state_next == IDLE) || lb;
      o_busy            <= state_next != IDLE;
      if_spi_din_valid  <= (state_next == SEND) && !lb;
      if_spi_dout_ready <= (state_next == WAIT_RX) && !lb;
      if (state_next == SEND) if_spi_din_bits <= tx_head;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)         o_rx_overflow <= 1'b0;
    else if (rx_drop)   o_rx_overflow <= 1'b1;
    else if (i_clr_ovf) o_rx_overflow <= 1'b0;
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a behavioural SPI byte engine returning din ^ 0x99.
`timescale 1ns/1ps
module tb_spi_xfer_ctrl;

  localparam int Xfer = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0, tx_ready;
  logic [7:0] tx_bits = 8'h00;
  logic       rx_valid, rx_ready = 1'b0;
  logic [7:0] rx_bits;
  logic       din_valid, din_ready;
  logic [7:0] din_bits;
  logic       dout_valid, dout_ready;
  logic [7:0] dout_bits;
  logic       cs_hold = 1'b0, clr_ovf = 1'b0;
  logic       cs_n, busy, rx_ovf;
  logic [4:0] tx_count, rx_count;
`ifdef SPI_XFER_CTRL_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  spi_xfer_ctrl #(.FifoDepth(16), .CsLeadCycles(2), .CsGapCycles(4)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .if_tx_valid(tx_valid), .if_tx_ready(tx_ready), .if_tx_bits(tx_bits),
    .if_rx_valid(rx_valid), .if_rx_ready(rx_ready), .if_rx_bits(rx_bits),
    .if_spi_din_valid(din_valid), .if_spi_din_ready(din_ready), .if_spi_din_bits(din_bits),
    .if_spi_dout_valid(dout_valid), .if_spi_dout_ready(dout_ready), .if_spi_dout_bits(dout_bits),
`ifdef SPI_XFER_CTRL_LOOPBACK_EN
    .i_loopback(loopback),
`endif
    .i_cs_hold(cs_hold), .i_clr_ovf(clr_ovf),
    .o_cs_n(cs_n), .o_busy(busy),
    .o_tx_count(tx_count), .o_rx_count(rx_count), .o_rx_overflow(rx_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: ready after Xfer cycles of valid, returned byte one cycle later
  logic       eng_stall = 1'b0;
  int         eng_cnt;
  logic       eng_pend;
  logic [7:0] eng_resp;
  logic [7:0] sent_q[$];
  int         hs_cyc[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_ready <= 1'b0; dout_valid <= 1'b0; dout_bits <= 8'h00;
      eng_cnt <= 0; eng_pend <= 1'b0; eng_resp <= 8'h00;
    end else begin
      din_ready  <= 1'b0;
      dout_valid <= 1'b0;
      if (eng_pend) begin
        dout_valid <= 1'b1; dout_bits <= eng_resp; eng_pend <= 1'b0;
      end
      if (din_valid && !din_ready && !eng_stall) begin
        if (eng_cnt == Xfer - 1) begin
          din_ready <= 1'b1; eng_pend <= 1'b1; eng_resp <= din_bits ^ 8'h99; eng_cnt <= 0;
          sent_q.push_back(din_bits); hs_cyc.push_back(cyc);
        end else begin
          eng_cnt <= eng_cnt + 1;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_cap(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if (dout_valid === 1'b1 && dout_ready === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      tick();
      if (busy === 1'b0 && tx_count === 5'd0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (cs_n !== 1'b1 || busy !== 1'b0 || rx_ovf !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: cs_n=%b busy=%b ovf=%b, expected 1 0 0", cs_n, busy, rx_ovf);
    end
    checks++;
    if (tx_count !== 5'd0 || rx_count !== 5'd0) begin
      errors++; $display("FAIL reset_counts: tx=%0d rx=%0d, expected 0 0", tx_count, rx_count);
    end
    checks++;
    if (din_valid !== 1'b0 || dout_ready !== 1'b0 || rx_valid !== 1'b0 || tx_ready !== 1'b1) begin
      errors++; $display("FAIL reset_handshake: din_v=%b dout_r=%b rx_v=%b tx_r=%b, expected 0 0 0 1",
                         din_valid, dout_ready, rx_valid, tx_ready);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_single_byte();
    bit ok;
    int low;
    tx_bits = 8'hA5; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
    checks++;
    if (tx_count !== 5'd1 || cs_n !== 1'b1) begin
      errors++; $display("FAIL single_push: tx=%0d cs_n=%b, expected 1 1", tx_count, cs_n);
    end
    tick();
    checks++;
    if (cs_n !== 1'b0 || busy !== 1'b1 || din_valid !== 1'b0) begin
      errors++; $display("FAIL single_cs_fall: cs_n=%b busy=%b din_v=%b, expected 0 1 0", cs_n, busy, din_valid);
    end
    tick();
    checks++;
    if (din_valid !== 1'b0) begin
      errors++; $display("FAIL single_lead: din_v=%b, expected 0", din_valid);
    end
    tick();
    checks++;
    if (din_valid !== 1'b1 || din_bits !== 8'hA5) begin
      errors++; $display("FAIL single_din: din_v=%b bits=%h, expected 1 a5", din_valid, din_bits);
    end
    wait_cap(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL single_capture: no dout capture within bound, expected one");
    end
    tick();
    checks++;
    if (rx_count !== 5'd1 || rx_valid !== 1'b1 || rx_bits !== 8'h3C || tx_count !== 5'd0) begin
      errors++; $display("FAIL single_rx: rx=%0d v=%b bits=%h tx=%0d, expected 1 1 3c 0",
                         rx_count, rx_valid, rx_bits, tx_count);
    end
    low = (cs_n === 1'b0) ? 1 : 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (cs_n === 1'b0) low++;
    end
    checks++;
    if (low != 4) begin
      errors++; $display("FAIL single_gap_low: cs_n low for %0d cycles after capture, expected 4", low);
    end
    tick();
    checks++;
    if (cs_n !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL single_gap_end: cs_n=%b busy=%b, expected 1 0", cs_n, busy);
    end
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    checks++;
    if (rx_count !== 5'd0 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL single_pop: rx=%0d v=%b, expected 0 0", rx_count, rx_valid);
    end
  endtask

  task automatic test_burst();
    bit ok;
    int glitch;
    logic [7:0] b;
    sent_q.delete(); hs_cyc.delete();
    for (int i = 1; i <= 4; i++) begin
      tx_bits = 8'(i); tx_valid = 1'b1; tick();
    end
    tx_valid = 1'b0;
    glitch = 0; ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (busy === 1'b1 && cs_n !== 1'b0) glitch++;
      if (busy === 1'b0 && tx_count === 5'd0) ok = 1'b1;
    end
    checks++;
    if (!ok || glitch != 0) begin
      errors++; $display("FAIL burst_cs: done=%b cs_n high %0d cycles while busy, expected 1 0", ok, glitch);
    end
    checks++;
    if (sent_q.size() != 4) begin
      errors++; $display("FAIL burst_count: %0d din handshakes, expected 4", sent_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sent_q[i] !== 8'(i + 1)) begin
          errors++; $display("FAIL burst_order: handshake %0d bits=%h, expected %h", i, sent_q[i], 8'(i + 1));
        end
      end
      for (int i = 1; i < 4; i++) begin
        if (hs_cyc[i] - hs_cyc[i-1] != Xfer + 2) begin
          errors++; $display("FAIL burst_spacing: %0d cycles between handshakes, expected %0d",
                             hs_cyc[i] - hs_cyc[i-1], Xfer + 2);
        end
      end
    end
    checks++;
    if (rx_count !== 5'd4 || tx_count !== 5'd0) begin
      errors++; $display("FAIL burst_counts: rx=%0d tx=%0d, expected 4 0", rx_count, tx_count);
    end
    for (int i = 1; i <= 4; i++) begin
      b = rx_bits; rx_ready = 1'b1; tick(); rx_ready = 1'b0;
      checks++;
      if (b !== (8'(i) ^ 8'h99)) begin
        errors++; $display("FAIL burst_rx: pop %0d got %h, expected %h", i, b, 8'(i) ^ 8'h99);
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [7:0] first, last;
    sent_q.delete();
    for (int i = 0; i < 16; i++) begin
      tx_bits = 8'h10 + 8'(i); tx_valid = 1'b1; tick();
    end
    tx_valid = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok || rx_count !== 5'd16 || rx_ovf !== 1'b0 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL ovf_fill: done=%b rx=%0d ovf=%b, expected 1 16 0", ok, rx_count, rx_ovf);
    end
    tx_bits = 8'h20; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok || rx_count !== 5'd16 || rx_ovf !== 1'b1 || sent_q.size() != 17) begin
      errors++; $display("FAIL ovf_drop: done=%b rx=%0d ovf=%b sent=%0d, expected 1 16 1 17",
                         ok, rx_count, rx_ovf, sent_q.size());
    end
    tick();
    checks++;
    if (rx_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: ovf=%b, expected 1", rx_ovf);
    end
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    checks++;
    if (rx_ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: ovf=%b, expected 0", rx_ovf);
    end
    clr_ovf = 1'b1;
    tx_bits = 8'h21; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
    wait_cap(ok);
    tick();
    checks++;
    if (!ok || rx_ovf !== 1'b1 || rx_count !== 5'd16) begin
      errors++; $display("FAIL ovf_set_wins: cap=%b ovf=%b rx=%0d, expected 1 1 16", ok, rx_ovf, rx_count);
    end
    tick();
    clr_ovf = 1'b0;
    checks++;
    if (rx_ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_clear_after: ovf=%b, expected 0", rx_ovf);
    end
    wait_idle(ok);
    tx_bits = 8'h77; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
    wait_cap(ok);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    checks++;
    if (!ok || rx_count !== 5'd16 || rx_ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_pop_push: cap=%b rx=%0d ovf=%b, expected 1 16 0", ok, rx_count, rx_ovf);
    end
    wait_idle(ok);
    first = rx_bits;
    last  = 8'h00;
    for (int i = 0; i < 16; i++) begin
      last = rx_bits; rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    end
    checks++;
    if (first !== 8'h88 || last !== 8'hEE || rx_count !== 5'd0) begin
      errors++; $display("FAIL ovf_drain: first=%h last=%h rx=%0d, expected 88 ee 0", first, last, rx_count);
    end
  endtask

  task automatic test_tx_full();
    bit ok;
    eng_stall = 1'b1;
    sent_q.delete();
    for (int i = 0; i < 16; i++) begin
      tx_bits = 8'h40 + 8'(i); tx_valid = 1'b1; tick();
    end
    tx_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (tx_count !== 5'd16 || tx_ready !== 1'b0) begin
      errors++; $display("FAIL txfull_level: tx=%0d ready=%b, expected 16 0", tx_count, tx_ready);
    end
    checks++;
    if (din_valid !== 1'b1 || din_bits !== 8'h40) begin
      errors++; $display("FAIL txfull_din_hold: din_v=%b bits=%h, expected 1 40", din_valid, din_bits);
    end
    tx_bits = 8'hEE; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
    checks++;
    if (tx_count !== 5'd16) begin
      errors++; $display("FAIL txfull_17th: tx=%0d, expected 16", tx_count);
    end
    eng_stall = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok || sent_q.size() != 16 || rx_count !== 5'd16) begin
      errors++; $display("FAIL txfull_drain: done=%b sent=%0d rx=%0d, expected 1 16 16", ok, sent_q.size(), rx_count);
    end else if (sent_q[15] !== 8'h4F) begin
      errors++; $display("FAIL txfull_last: last sent=%h, expected 4f", sent_q[15]);
    end
    for (int i = 0; i < 16; i++) begin
      rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    end
  endtask

  task automatic test_hold();
    bit ok;
    int low;
    logic [7:0] b;
    cs_hold = 1'b1;
    tx_bits = 8'h11; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
    wait_cap(ok);
    tick(); tick(); tick();
    checks++;
    if (!ok || cs_n !== 1'b0 || busy !== 1'b1 || din_valid !== 1'b0) begin
      errors++; $display("FAIL hold_state: cap=%b cs_n=%b busy=%b din_v=%b, expected 1 0 1 0",
                         ok, cs_n, busy, din_valid);
    end
    tx_bits = 8'h55; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
    checks++;
    if (din_valid !== 1'b0 || tx_count !== 5'd1) begin
      errors++; $display("FAIL hold_push: din_v=%b tx=%0d, expected 0 1", din_valid, tx_count);
    end
    tick();
    checks++;
    if (din_valid !== 1'b1 || din_bits !== 8'h55 || cs_n !== 1'b0) begin
      errors++; $display("FAIL hold_resend: din_v=%b bits=%h cs_n=%b, expected 1 55 0", din_valid, din_bits, cs_n);
    end
    wait_cap(ok);
    tick();
    cs_hold = 1'b0;
    low = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (cs_n === 1'b0) low++;
    end
    tick();
    checks++;
    if (!ok || low != 4 || cs_n !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL hold_release: cap=%b gap_low=%0d cs_n=%b busy=%b, expected 1 4 1 0",
                         ok, low, cs_n, busy);
    end
    b = rx_bits; rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    checks++;
    if (b !== 8'h88 || rx_count !== 5'd1 || rx_bits !== 8'hCC) begin
      errors++; $display("FAIL hold_rx: pop=%h rx=%0d head=%h, expected 88 1 cc", b, rx_count, rx_bits);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    eng_stall = 1'b1;
    tx_bits = 8'h99; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (din_valid === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok || tx_count !== 5'd1) begin
      errors++; $display("FAIL areset_setup: send=%b tx=%0d, expected 1 1", ok, tx_count);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cs_n !== 1'b1 || din_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL areset_ctrl: cs_n=%b din_v=%b busy=%b, expected 1 0 0", cs_n, din_valid, busy);
    end
    checks++;
    if (tx_count !== 5'd0 || rx_count !== 5'd0 || tx_ready !== 1'b1 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL areset_fifo: tx=%0d rx=%0d tx_r=%b rx_v=%b, expected 0 0 1 0",
                         tx_count, rx_count, tx_ready, rx_valid);
    end
    @(negedge clk) rst_n = 1'b1;
    eng_stall = 1'b0;
    tick();
    checks++;
    if (cs_n !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL areset_after: cs_n=%b busy=%b, expected 1 0", cs_n, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_overflow();
    test_tx_full();
    test_hold();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
